// File: rtl/dilated_tap_packer_pkg.sv
// Shared types and helpers for the dilated tap packer and its dot-product consumer.
package dilated_tap_packer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        PRESENT
    } state_e;

    // Number of samples the ring must hold to reach the oldest dilated tap.
    function automatic int ring_depth(input int d, input int dil);
        return (d - 1) * dil + 1;
    endfunction

    // LSB of tap j in a packed vector; tap 0 (newest) sits in the top slice.
    function automatic int tap_lsb(input int d, input int w, input int j);
        return w * (d - j - 1);
    endfunction

endpackage

// File: rtl/dilated_tap_packer_ring.sv
// Activation history ring: register array with combinational read, write pointer and fill count.
module tap_ring_buffer #(
    parameter int W  = 16,
    parameter int L  = 16,
    parameter int AW = (L > 1) ? $clog2(L) : 1,
    parameter int FW = $clog2(L + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          adv_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o,
    output logic [AW-1:0] wp_o,
    output logic [FW-1:0] fill_o
);

    logic [W-1:0]  mem_q [L];
    logic [AW-1:0] wp_q;
    logic [FW-1:0] fill_q;

    // Contents are deliberately left unreset; stale entries are masked by the fill count.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wp_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            fill_q <= '0;
        end else begin
            if (wr_en_i && (fill_q != FW'(L))) begin
                fill_q <= fill_q + 1'b1;
            end
            if (adv_i) begin
                wp_q <= (wp_q == AW'(L - 1)) ? '0 : wp_q + 1'b1;
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
    assign wp_o      = wp_q;
    assign fill_o    = fill_q;

endmodule

// File: rtl/dilated_tap_packer.sv
// Gathers D dilated causal taps per accepted sample and presents them to the dot-product engine.
module dilated_tap_packer
    import dilated_tap_packer_pkg::*;
#(
    parameter int W   = 16,
    parameter int D   = 16,
    parameter int DIL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_sample_i,
    input  logic           in_v_i,
    output logic           in_ready_o,
    output logic [D*W-1:0] packed_a_o,
    output logic           packed_v_o,
    output logic           dp_start_o,
    input  logic           dp_done_i
);

    localparam int L  = ring_depth(D, DIL);
    localparam int AW = (L > 1) ? $clog2(L) : 1;
    localparam int FW = $clog2(L + 1);
    localparam int JW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = AW + 1;

    state_e         state_q;
    logic [JW-1:0]  j_q;
    logic           in_ready_q;
    logic           packed_v_q;
    logic           dp_start_q;
    logic [D*W-1:0] packed_a_q;
    logic [D*W-1:0] stage_q;
    logic [D*W-1:0] stage_d;

    logic           wr_en;
    logic           adv;
    logic [AW-1:0]  wp;
    logic [FW-1:0]  fill;
    logic [AW-1:0]  rd_addr;
    logic [W-1:0]   rd_data;
    logic [CW-1:0]  off;
    logic [CW-1:0]  wp_ext;
    logic [CW-1:0]  addr_wide;
    logic [W-1:0]   tap;

    // The first PRESENT cycle is skipped so a stale out_v from the previous job is not taken as done.
    assign wr_en = (state_q == IDLE) && in_v_i;
    assign adv   = (state_q == PRESENT) && !dp_start_q && dp_done_i;

    tap_ring_buffer #(
        .W (W),
        .L (L)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (in_sample_i),
        .adv_i     (adv),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wp_o      (wp),
        .fill_o    (fill)
    );

    // Offset never exceeds L-1, so one conditional add of L performs the modulo.
    always_comb begin
        off       = CW'(int'(j_q) * DIL);
        wp_ext    = {1'b0, wp};
        addr_wide = (wp_ext >= off) ? (wp_ext - off) : (wp_ext + CW'(L) - off);
        rd_addr   = addr_wide[AW-1:0];
        tap       = (32'(fill) > 32'(off)) ? rd_data : '0;
        stage_d   = stage_q;
        stage_d[tap_lsb(D, W, int'(j_q)) +: W] = tap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            in_ready_q <= 1'b1;
            packed_v_q <= 1'b0;
            dp_start_q <= 1'b0;
            packed_a_q <= '0;
            stage_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_v_i) begin
                        in_ready_q <= 1'b0;
                        j_q        <= '0;
                        state_q    <= GATHER;
                    end
                end
                GATHER: begin
                    stage_q <= stage_d;
                    if (j_q == JW'(D - 1)) begin
                        packed_a_q <= stage_d;
                        packed_v_q <= 1'b1;
                        dp_start_q <= 1'b1;
                        j_q        <= '0;
                        state_q    <= PRESENT;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                PRESENT: begin
                    dp_start_q <= 1'b0;
                    if (adv) begin
                        packed_v_q <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign packed_a_o = packed_a_q;
    assign packed_v_o = packed_v_q;
    assign dp_start_o = dp_start_q;

endmodule

// File: tb/tb_dilated_tap_packer.sv
// Directed bench for dilated_tap_packer with W=16, D=4, DIL=2 and a 3-cycle dot-product model.
module tb_dilated_tap_packer;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int DIL = 2;

    typedef struct {
        logic [W-1:0]   sample;
        logic [D*W-1:0] expVec;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   inSample;
    logic           inV;
    logic           inReady;
    logic [D*W-1:0] packedA;
    logic           packedV;
    logic           dpStart;
    logic           dpDone;
    logic           engDone = 1'b0;
    logic           forceDone = 1'b0;
    int             engCnt = 0;

    int checks = 0;
    int failures = 0;
    vec_t tbl [9];

    dilated_tap_packer #(
        .W   (W),
        .D   (D),
        .DIL (DIL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_sample_i (inSample),
        .in_v_i      (inV),
        .in_ready_o  (inReady),
        .packed_a_o  (packedA),
        .packed_v_o  (packedV),
        .dp_start_o  (dpStart),
        .dp_done_i   (dpDone)
    );

    always #5 clk = ~clk;

    assign dpDone = engDone | forceDone;

    // Dot-product model: out_v for one cycle, three cycles after dp_start is seen.
    always @(negedge clk) begin
        if (rst) begin
            engCnt  = 0;
            engDone = 1'b0;
        end else if (dpStart) begin
            engCnt  = 3;
            engDone = 1'b0;
        end else if (engCnt > 0) begin
            engCnt  = engCnt - 1;
            engDone = (engCnt == 0);
        end else begin
            engDone = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One full transaction: accept x, expect the vector 5 cycles later, hold it, release on done.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [D*W-1:0] expVec,
                                 input bit doneOnStart, input string tag);
        int n;
        logic [D*W-1:0] held;
        @(negedge clk);
        n = 0;
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " in_ready idle"}, 64'(inReady), 64'd1);
        inV      = 1'b1;
        inSample = x;
        @(negedge clk);
        inV = 1'b0;
        checkOutput({tag, " in_ready gather"}, 64'(inReady), 64'd0);
        n = 1;
        while (!packedV && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'd5);
        checkOutput({tag, " dp_start"}, 64'(dpStart), 64'd1);
        checkOutput({tag, " packed_a"}, packedA, expVec);
        held = packedA;
        if (doneOnStart) forceDone = 1'b1;
        @(negedge clk);
        forceDone = 1'b0;
        checkOutput({tag, " dp_start pulse"}, 64'(dpStart), 64'd0);
        checkOutput({tag, " packed_v hold"}, 64'(packedV), 64'd1);
        n = 0;
        while (packedV && n < 30) begin
            checkOutput({tag, " packed_a stable"}, packedA, held);
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " present length"}, 64'(n), 64'd3);
        checkOutput({tag, " in_ready back"}, 64'(inReady), 64'd1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int idx;
        int vecIdx;
        int readyCycles;
        int n;
        logic [D*W-1:0] held;

        tbl[0] = '{16'h0001, 64'h0001_0000_0000_0000};
        tbl[1] = '{16'h0002, 64'h0002_0000_0000_0000};
        tbl[2] = '{16'h0003, 64'h0003_0001_0000_0000};
        tbl[3] = '{16'h0004, 64'h0004_0002_0000_0000};
        tbl[4] = '{16'h0005, 64'h0005_0003_0001_0000};
        tbl[5] = '{16'h0006, 64'h0006_0004_0002_0000};
        tbl[6] = '{16'h0007, 64'h0007_0005_0003_0001};
        tbl[7] = '{16'h0008, 64'h0008_0006_0004_0002};
        tbl[8] = '{16'h0009, 64'h0009_0007_0005_0003};

        rst      = 1'b1;
        inV      = 1'b0;
        inSample = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 64'(inReady), 64'd1);
        checkOutput("reset packed_v", 64'(packedV), 64'd0);
        checkOutput("reset dp_start", 64'(dpStart), 64'd0);
        checkOutput("reset packed_a", packedA, 64'd0);
        rst = 1'b0;

        // Samples 1..9 one at a time: fill growth, saturation and pointer wrap.
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                @(negedge clk);
                forceDone = 1'b1;
                repeat (2) @(negedge clk);
                forceDone = 1'b0;
                checkOutput("idle done in_ready", 64'(inReady), 64'd1);
                checkOutput("idle done packed_v", 64'(packedV), 64'd0);
            end
            applyStimulus(tbl[i].sample, tbl[i].expVec, (i == 1), $sformatf("vec%0d", i + 1));
        end

        // Source holds in_v high the whole time.
        pulseReset();
        idx         = 0;
        vecIdx      = 0;
        readyCycles = 0;
        held        = '0;
        for (int c = 0; c < 600 && vecIdx < 9; c++) begin
            @(negedge clk);
            if (packedV) begin
                checkOutput("stream in_ready busy", 64'(inReady), 64'd0);
                if (dpStart) begin
                    checkOutput($sformatf("stream vec%0d", vecIdx + 1), packedA, tbl[vecIdx].expVec);
                    held = packedA;
                    vecIdx++;
                end else begin
                    checkOutput("stream packed_a stable", packedA, held);
                end
            end
            if (idx < 9) begin
                inV      = 1'b1;
                inSample = tbl[idx].sample;
                if (inReady) begin
                    readyCycles++;
                    idx++;
                end
            end else begin
                inV = 1'b0;
            end
        end
        inV = 1'b0;
        checkOutput("stream vectors", 64'(vecIdx), 64'd9);
        checkOutput("stream accepts", 64'(idx), 64'd9);
        checkOutput("stream ready cycles", 64'(readyCycles), 64'd9);
        n = 0;
        while (packedV && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stream drained", 64'(packedV), 64'd0);

        // Reset during GATHER of the 5th sample.
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(tbl[i].sample, tbl[i].expVec, 1'b0, $sformatf("pre%0d", i + 1));
        end
        @(negedge clk);
        inV      = 1'b1;
        inSample = 16'h0005;
        @(negedge clk);
        inV = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset packed_v", 64'(packedV), 64'd0);
        checkOutput("midreset dp_start", 64'(dpStart), 64'd0);
        checkOutput("midreset packed_a", packedA, 64'd0);
        checkOutput("midreset in_ready", 64'(inReady), 64'd1);
        rst = 1'b0;
        applyStimulus(16'h00AB, 64'h00AB_0000_0000_0000, 1'b0, "postreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
